vp_stride_table: RTL and testbench

Stride-based load-value predictor table sitting directly upstream of `value_prediction`. It is looked up by load PC and returns a predicted load value plus a confidence flag that gates `vp_en`. It is trained with the actual D-cache load data once the load resolves. A clear sweep invalidates every entry after reset or on `flush`.

---
 rtl/vp_pkg.sv | 36 +++
 rtl/vp_entry_ram.sv | 52 +++++
 rtl/vp_stride_table.sv | 179 +++++++++++++++++
 tb/tb_vp_stride_table.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared types and defaults for the stride load-value predictor.
//   ADDR_WIDTH / DATA_WIDTH : core address and data widths (mirror mips_core)
//   VP_INDEX_WIDTH          : default log2 of table entries
//   VP_CONF_WIDTH           : confidence counter width (also the stored field)
//   VP_CONF_THRESH          : default confidence threshold
//   vp_entry_t              : one table entry
//   vp_state_e              : sweep FSM states
// ---------------------------------------------------------------------------
package vp_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int VP_INDEX_WIDTH = 6;
    localparam int VP_CONF_WIDTH  = 2;
    localparam int VP_CONF_THRESH = 2;

    // The tag field is sized for the smallest possible index (pc >> 2), so
    // one entry type serves every INDEX_WIDTH. Tags are stored zero-extended.
    localparam int TAG_FIELD_WIDTH = ADDR_WIDTH - 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } vp_state_e;

    typedef struct packed {
        logic                       valid;
        logic [TAG_FIELD_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0]      last_value;
        logic [DATA_WIDTH-1:0]      stride;
        logic [VP_CONF_WIDTH-1:0]   conf;
    } vp_entry_t;

endpackage

// File: rtl/vp_entry_ram.sv
// ---------------------------------------------------------------------------
// vp_entry_ram
// 2^INDEX_WIDTH x vp_entry_t storage.
//   clk          : clock
//   rd_en_i      : lookup read enable
//   rd_addr_i    : lookup read index
//   rd_data_o    : registered lookup data (read-first against a same-edge write)
//   peek_addr_i  : training index
//   peek_data_o  : combinational view of the training entry
//   wr_en_i      : write enable (single write port)
//   wr_addr_i    : write index
//   wr_data_i    : write data
// ---------------------------------------------------------------------------
module vp_entry_ram
    import vp_pkg::*;
#(
    parameter int INDEX_WIDTH = VP_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rd_en_i,
    input  logic [INDEX_WIDTH-1:0] rd_addr_i,
    output vp_entry_t              rd_data_o,
    input  logic [INDEX_WIDTH-1:0] peek_addr_i,
    output vp_entry_t              peek_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_addr_i,
    input  vp_entry_t              wr_data_i
);

    localparam int ENTRIES = 2 ** INDEX_WIDTH;

    vp_entry_t mem_q [ENTRIES];
    vp_entry_t rd_data_q;

    // Non-blocking read and write on the same edge: the lookup sees the
    // entry as it was before this cycle's write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

    // Training is read-modify-write within one cycle, so it needs the stored
    // entry before the edge it commits on.
    assign peek_data_o = mem_q[peek_addr_i];

endmodule

// File: rtl/vp_stride_table.sv
// ---------------------------------------------------------------------------
// vp_stride_table
// Stride-based load-value predictor table, looked up by load PC.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : one-cycle pulse, restarts the clear sweep
//   req_valid/pc    : lookup request (accepted when req_ready)
//   req_ready       : low while the clear sweep runs
//   pred_valid      : one-cycle pulse, cycle after an accepted lookup
//   pred_hit        : valid entry with matching tag
//   pred_value      : last_value + stride, 0 on miss
//   pred_confident  : hit and conf >= CONF_THRESH
//   train_valid/pc/value : training update with resolved load data
//   clearing        : clear sweep in progress (FSM state)
// Handshake: a lookup is taken on any edge where req_valid && req_ready;
// there is no backpressure on the pred_* side.
// ---------------------------------------------------------------------------
module vp_stride_table
    import vp_pkg::*;
#(
    parameter int INDEX_WIDTH = VP_INDEX_WIDTH,
    // Must not exceed VP_CONF_WIDTH, the stored field width.
    parameter int CONF_WIDTH  = VP_CONF_WIDTH,
    parameter int CONF_THRESH = VP_CONF_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    output logic                  req_ready,
    output logic                  pred_valid,
    output logic                  pred_hit,
    output logic [DATA_WIDTH-1:0] pred_value,
    output logic                  pred_confident,
    input  logic                  train_valid,
    input  logic [ADDR_WIDTH-1:0] train_pc,
    input  logic [DATA_WIDTH-1:0] train_value,
    output logic                  clearing
);

    localparam int ENTRIES = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0]   LAST_IDX = INDEX_WIDTH'(ENTRIES - 1);
    localparam logic [VP_CONF_WIDTH-1:0] CONF_MAX = VP_CONF_WIDTH'((1 << CONF_WIDTH) - 1);
    localparam logic [VP_CONF_WIDTH-1:0] CONF_TH  = VP_CONF_WIDTH'(CONF_THRESH);

    function automatic logic [INDEX_WIDTH-1:0] index_of(input logic [ADDR_WIDTH-1:0] pc);
        return pc[INDEX_WIDTH+1:2];
    endfunction

    function automatic logic [TAG_FIELD_WIDTH-1:0] tag_of(input logic [ADDR_WIDTH-1:0] pc);
        return TAG_FIELD_WIDTH'(pc >> (INDEX_WIDTH + 2));
    endfunction

    // ---------------- sweep FSM ----------------
    vp_state_e              state_q, state_d;
    logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (flush) begin
            state_d = CLEAR;
            sweep_d = '0;
        end else if (state_q == CLEAR) begin
            sweep_d = sweep_q + INDEX_WIDTH'(1);
            if (sweep_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign clearing  = (state_q == CLEAR);
    assign req_ready = (state_q == READY);

    logic lookup;
    assign lookup = req_valid & req_ready;

    // ---------------- training arithmetic ----------------
    vp_entry_t              train_old;
    vp_entry_t              train_new;
    logic [TAG_FIELD_WIDTH-1:0] train_tag;
    logic                   train_hit;
    logic [DATA_WIDTH-1:0]  new_stride;

    assign train_tag  = tag_of(train_pc);
    assign train_hit  = train_old.valid && (train_old.tag == train_tag);
    assign new_stride = train_value - train_old.last_value;

    always_comb begin
        // Miss: allocate fresh, no stride history yet.
        train_new            = '0;
        train_new.valid      = 1'b1;
        train_new.tag        = train_tag;
        train_new.last_value = train_value;
        if (train_hit) begin
            if (new_stride == train_old.stride) begin
                train_new.stride = train_old.stride;
                train_new.conf   = (train_old.conf == CONF_MAX) ? train_old.conf
                                                                : train_old.conf + VP_CONF_WIDTH'(1);
            end else begin
                train_new.stride = new_stride;
                train_new.conf   = '0;
            end
        end
    end

    // Single write port: the sweep owns it while clearing, which is also
    // why training is dropped during CLEAR.
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_addr;
    vp_entry_t              wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = index_of(train_pc);
        wr_data = train_new;
        if (!rst) begin
            if (clearing) begin
                wr_en   = 1'b1;
                wr_addr = sweep_q;
                wr_data = '0;
            end else if (train_valid) begin
                wr_en = 1'b1;
            end
        end
    end

    // ---------------- storage ----------------
    vp_entry_t rd_entry;

    vp_entry_ram #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_ram (
        .clk         (clk),
        .rd_en_i     (lookup),
        .rd_addr_i   (index_of(req_pc)),
        .rd_data_o   (rd_entry),
        .peek_addr_i (index_of(train_pc)),
        .peek_data_o (train_old),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data)
    );

    // ---------------- lookup result ----------------
    logic                       pred_valid_q;
    logic [TAG_FIELD_WIDTH-1:0] req_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
        end else begin
            pred_valid_q <= lookup;
        end
        if (lookup) begin
            req_tag_q <= tag_of(req_pc);
        end
    end

    // The RAM read register is the data stage; everything is gated by
    // pred_valid_q so idle cycles and reset present all-zero outputs.
    logic look_hit;
    assign look_hit       = pred_valid_q && rd_entry.valid && (rd_entry.tag == req_tag_q);
    assign pred_valid     = pred_valid_q;
    assign pred_hit       = look_hit;
    assign pred_value     = look_hit ? (rd_entry.last_value + rd_entry.stride) : '0;
    assign pred_confident = look_hit && (rd_entry.conf >= CONF_TH);

endmodule

// File: tb/tb_vp_stride_table.sv
module tb_vp_stride_table;
    import vp_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  flush;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_ready;
    logic                  pred_valid;
    logic                  pred_hit;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  pred_confident;
    logic                  train_valid;
    logic [ADDR_WIDTH-1:0] train_pc;
    logic [DATA_WIDTH-1:0] train_value;
    logic                  clearing;

    vp_stride_table dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_ready      (req_ready),
        .pred_valid     (pred_valid),
        .pred_hit       (pred_hit),
        .pred_value     (pred_value),
        .pred_confident (pred_confident),
        .train_valid    (train_valid),
        .train_pc       (train_pc),
        .train_value    (train_value),
        .clearing       (clearing)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic hit, input logic [31:0] value,
                              input logic conf);
        check_eq({tag, ".valid"}, 64'(pred_valid), 64'd1);
        check_eq({tag, ".hit"}, 64'(pred_hit), 64'(hit));
        check_eq({tag, ".value"}, 64'(pred_value), 64'(value));
        check_eq({tag, ".conf"}, 64'(pred_confident), 64'(conf));
    endtask

    // ---------------- drivers ----------------
    task automatic do_train(input logic [31:0] pc, input logic [31:0] value);
        @(negedge clk);
        train_valid = 1'b1;
        train_pc    = pc;
        train_value = value;
        @(negedge clk);
        train_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts negedges with clearing high; checks req_ready stays low. Drives
    // a dropped request and an ignored train partway through the sweep.
    task automatic count_clear(input string tag, input logic poke);
        int  n;
        logic bad_ready;
        n = 0;
        bad_ready = 1'b0;
        while (clearing && n < 200) begin
            if (req_ready) bad_ready = 1'b1;
            if (poke) begin
                if (n == 10) check_eq({tag, ".dropped_req"}, 64'(pred_valid), 64'd0);
                case (n)
                    9:  begin req_valid = 1'b1; req_pc = 32'h1000; end
                    10: req_valid = 1'b0;
                    20: begin train_valid = 1'b1; train_pc = 32'h2000; train_value = 32'h55; end
                    21: train_valid = 1'b0;
                    default: ;
                endcase
            end
            n++;
            @(negedge clk);
        end
        check_eq({tag, ".cycles"}, 64'(n), 64'd64);
        check_eq({tag, ".ready_low"}, 64'(bad_ready), 64'd0);
        check_eq({tag, ".ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        req_pc = '0;
        train_valid = 1'b0;
        train_pc = '0;
        train_value = '0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset.clearing", 64'(clearing), 64'd1);
        check_eq("reset.req_ready", 64'(req_ready), 64'd0);
        check_eq("reset.pred_valid", 64'(pred_valid), 64'd0);
        check_eq("reset.pred_value", 64'(pred_value), 64'd0);
        count_clear("reset_sweep", 1'b0);

        do_lookup(32'h400);
        check_pred("empty", 1'b0, 32'h0, 1'b0);

        // stride learning
        do_train(32'h1000, 32'h10);
        do_train(32'h1000, 32'h14);
        do_train(32'h1000, 32'h18);
        do_train(32'h1000, 32'h1C);
        do_lookup(32'h1000);
        check_pred("learn", 1'b1, 32'h20, 1'b1);

        // stride break
        do_train(32'h1000, 32'h50);
        do_lookup(32'h1000);
        check_pred("break", 1'b1, 32'h84, 1'b0);

        // alias eviction, checked with back-to-back lookups
        do_train(32'h1100, 32'h7);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = 32'h1000;
        @(negedge clk);
        req_pc = 32'h1100;
        check_pred("alias_old", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        check_pred("alias_new", 1'b1, 32'h7, 1'b0);
        @(negedge clk);
        check_eq("idle.pred_valid", 64'(pred_valid), 64'd0);

        // negative stride, confidence saturation
        do_train(32'h3004, 32'h100);
        do_train(32'h3004, 32'hF0);
        do_train(32'h3004, 32'hE0);
        do_lookup(32'h3004);
        check_pred("neg_stride", 1'b1, 32'hD0, 1'b0);
        do_train(32'h3004, 32'hD0);
        do_train(32'h3004, 32'hC0);
        do_train(32'h3004, 32'hB0);
        do_lookup(32'h3004);
        check_pred("conf_sat", 1'b1, 32'hA0, 1'b1);

        // 32-bit wrap of the prediction
        do_train(32'h3008, 32'hFFFF_FFF0);
        do_train(32'h3008, 32'hFFFF_FFF8);
        do_lookup(32'h3008);
        check_pred("wrap", 1'b1, 32'h0, 1'b0);

        // same-cycle lookup and train on a confident entry
        do_train(32'h1000, 32'h10);
        do_train(32'h1000, 32'h14);
        do_train(32'h1000, 32'h18);
        do_train(32'h1000, 32'h1C);
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = 32'h1000;
        train_valid = 1'b1;
        train_pc = 32'h1000;
        train_value = 32'h99;
        @(negedge clk);
        train_valid = 1'b0;
        check_pred("same_cycle_old", 1'b1, 32'h20, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check_pred("same_cycle_new", 1'b1, 32'h116, 1'b0);

        // flush with a lookup in flight
        @(negedge clk);
        req_valid = 1'b1;
        req_pc = 32'h1000;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check_pred("flush_inflight", 1'b1, 32'h116, 1'b0);
        check_eq("flush.clearing", 64'(clearing), 64'd1);
        count_clear("flush_sweep", 1'b1);

        do_lookup(32'h1000);
        check_pred("post_flush_1000", 1'b0, 32'h0, 1'b0);
        do_lookup(32'h3004);
        check_pred("post_flush_3004", 1'b0, 32'h0, 1'b0);
        do_lookup(32'h2000);
        check_pred("train_in_clear", 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
